maincontrol_fsm: RTL

- Multicycle MIPS main controller: the producer of the `aluop` code that the ALU decoder consumes.
- Sequences each instruction through fetch, decode, execute, memory and writeback states, and issues per-state datapath controls.
- Sits in the controller beside the ALU decoder. It takes `op` from the instruction register and `zero` from the ALU, and drives the multicycle datapath.

---
 rtl/maincontrol_fsm.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/maincontrol_fsm.sv
// maincontrol_fsm
// Multicycle MIPS main controller. Walks each instruction through
// fetch / decode / execute / memory / writeback states and decodes the
// datapath controls (Moore) from the current state. Produces the aluop
// code consumed by the ALU decoder.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   op[5:0]           opcode from the instruction register (instr[31:26])
//   zero              ALU zero flag, only used for pcen in BEQEX
//   aluop[1:0]        00 add, 01 sub, 10 use funct
//   alusrca           0 = PC, 1 = register A
//   alusrcb[1:0]      00 B, 01 const 4, 10 signimm, 11 signimm<<2
//   pcsrc[1:0]        00 ALU result, 01 ALUOut, 10 jump target
//   iord, irwrite, memwrite, regwrite, regdst, memtoreg, branch, pcwrite
//   pcen              pcwrite | (branch & zero)
//   illegal           one-cycle pulse in DECODE on an undecodable opcode
//   state[STATE_W-1:0] current state encoding, zero-extended
//
// Parameters:
//   ILLEGAL_HALT      0: illegal opcode returns to FETCH; 1: parks in HALT
//   STATE_W           width of the state debug port (>= 4)

module maincontrol_fsm #(
    parameter bit ILLEGAL_HALT = 1'b0,
    parameter int STATE_W      = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic               zero,
    output logic [1:0]         aluop,
    output logic               alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         pcsrc,
    output logic               iord,
    output logic               irwrite,
    output logic               memwrite,
    output logic               regwrite,
    output logic               regdst,
    output logic               memtoreg,
    output logic               branch,
    output logic               pcwrite,
    output logic               pcen,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11,
        S_HALT    = 4'd15
    } state_t;

    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state_q, state_d;

    // Ungated state decode; write enables are masked by reset below.
    logic irwrite_raw, memwrite_raw, regwrite_raw, pcwrite_raw, illegal_raw;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next state. op is only looked at in DECODE and MEMADR.
    always_comb begin
        state_d     = S_FETCH;
        illegal_raw = 1'b0;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JEX;
                    default: begin
                        illegal_raw = 1'b1;
                        state_d     = ILLEGAL_HALT ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_MEMADR:  state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            S_HALT:    state_d = S_HALT;
            // Writeback/terminal states and unused encodings 12-14.
            default:   state_d = S_FETCH;
        endcase
    end

    // Moore output decode; anything not set for a state stays 0.
    always_comb begin
        aluop        = 2'b00;
        alusrca      = 1'b0;
        alusrcb      = 2'b00;
        pcsrc        = 2'b00;
        iord         = 1'b0;
        irwrite_raw  = 1'b0;
        memwrite_raw = 1'b0;
        regwrite_raw = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        branch       = 1'b0;
        pcwrite_raw  = 1'b0;
        case (state_q)
            S_FETCH: begin
                irwrite_raw = 1'b1;
                pcwrite_raw = 1'b1;
                alusrcb     = 2'b01;
            end
            S_DECODE:  alusrcb = 2'b11;
            S_MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_MEMRD:   iord = 1'b1;
            S_MEMWB: begin
                regwrite_raw = 1'b1;
                memtoreg     = 1'b1;
            end
            S_MEMWR: begin
                iord         = 1'b1;
                memwrite_raw = 1'b1;
            end
            S_RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
            end
            S_RTYPEWB: begin
                regwrite_raw = 1'b1;
                regdst       = 1'b1;
            end
            S_BEQEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            S_ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
            end
            S_ADDIWB:  regwrite_raw = 1'b1;
            S_JEX: begin
                pcwrite_raw = 1'b1;
                pcsrc       = 2'b10;
            end
            default: ;
        endcase
    end

    // No architectural write may happen in a cycle where reset is high,
    // even though the state register still shows the pre-reset state.
    assign irwrite  = irwrite_raw  & ~reset;
    assign memwrite = memwrite_raw & ~reset;
    assign regwrite = regwrite_raw & ~reset;
    assign pcwrite  = pcwrite_raw  & ~reset;
    assign pcen     = (pcwrite_raw | (branch & zero)) & ~reset;
    assign illegal  = illegal_raw  & ~reset;
    assign state    = STATE_W'(state_q);

endmodule
